// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_t;

    localparam logic [1:0] W_WORD     = 2'b00;
    localparam logic [1:0] W_HALF     = 2'b01;
    localparam logic [1:0] W_BYTE     = 2'b10;
    localparam logic [1:0] W_WORD_ALT = 2'b11;

    localparam int unsigned DMEM_BYTES_DEFAULT = 4096;

    // Number of bytes touched by an access of the given width code.
    function automatic logic [2:0] width_bytes(input logic [1:0] w);
        case (w)
            W_HALF:  width_bytes = 3'd2;
            W_BYTE:  width_bytes = 3'd1;
            default: width_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/dmem_rr_arb.sv
// Two-way round-robin grant. The last-grant register only moves when the
// granted request is actually accepted, so a waiting requester keeps priority.
module dmem_rr_arb
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic       grant
);

    logic last;

    // Lone requester wins; on contention the one not served last wins.
    always_comb begin
        case (valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            default: grant = ~last;
        endcase
    end

    // Remember the winner of each accepted handshake; reset favours requester 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (accept) begin
            last <= grant;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: two requesters share one memory port, one transaction
// in flight (IDLE -> ISSUE -> RESP, or IDLE -> RESP for a rejected access).
// Optional macro DMEM_ARB_ALIGN_CHECK_EN also rejects misaligned word/half
// accesses; without it only the address range is checked.
//
// Handshake: a request is accepted on a rising edge where rq_valid[g] and
// rq_ready[g] are both 1. rq_ready is only ever raised in IDLE for the
// granted requester while it is valid. Responses (rs_valid) are a single
// cycle strobe with no backpressure.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DMEM_BYTES = DMEM_BYTES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  rq_valid,
    output logic [1:0]  rq_ready,
    input  logic [1:0]  rq_we,
    input  logic [1:0]  rq_signext,
    input  logic [1:0]  rq_width0,
    input  logic [1:0]  rq_width1,
    input  logic [31:0] rq_addr0,
    input  logic [31:0] rq_addr1,
    input  logic [31:0] rq_wdata0,
    input  logic [31:0] rq_wdata1,
    output logic [1:0]  rs_valid,
    output logic        rs_err,
    output logic [31:0] rs_rdata,
    output logic        mem_data_i,
    output logic        mem_data_o,
    output logic [1:0]  mem_width,
    output logic        mem_signext,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_read,
    output arb_state_t  dbg_state
);

    arb_state_t  state, state_nxt;
    logic        grant;
    logic        handshake;
    logic        sel_we, sel_signext, req_err;
    logic [1:0]  sel_width;
    logic [31:0] sel_addr, sel_wdata;
    logic [32:0] end_addr;

    logic        we_q, signext_q, owner_q, err_q;
    logic [1:0]  width_q;
    logic [31:0] addr_q, wdata_q;

    dmem_rr_arb u_rr (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid  (rq_valid),
        .accept (handshake),
        .grant  (grant)
    );

    // Route the granted requester's fields and classify the access.
    always_comb begin
        sel_we      = rq_we[grant];
        sel_signext = rq_signext[grant];
        sel_width   = grant ? rq_width1 : rq_width0;
        sel_addr    = grant ? rq_addr1  : rq_addr0;
        sel_wdata   = grant ? rq_wdata1 : rq_wdata0;
        // 33-bit sum so an address near 2^32 cannot wrap into range.
        end_addr    = {1'b0, sel_addr} + {30'd0, width_bytes(sel_width)};
        req_err     = end_addr > 33'(DMEM_BYTES);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        if (((sel_width == W_WORD) || (sel_width == W_WORD_ALT)) && (sel_addr[1:0] != 2'b00))
            req_err = 1'b1;
        if ((sel_width == W_HALF) && sel_addr[0])
            req_err = 1'b1;
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake decode.
    always_comb begin
        state_nxt = state;
        handshake = (state == ST_IDLE) && rst_n && rq_valid[grant];
        rq_ready  = 2'b00;
        if (handshake) rq_ready = grant ? 2'b10 : 2'b01;
        case (state)
            ST_IDLE:  if (handshake) state_nxt = req_err ? ST_RESP : ST_ISSUE;
            ST_ISSUE: state_nxt = ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Capture the accepted request; reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q      <= 1'b0;
            signext_q <= 1'b0;
            owner_q   <= 1'b0;
            err_q     <= 1'b0;
            width_q   <= W_WORD;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
        end else if (handshake) begin
            we_q      <= sel_we;
            signext_q <= sel_signext;
            owner_q   <= grant;
            err_q     <= req_err;
            width_q   <= sel_width;
            addr_q    <= sel_addr;
            wdata_q   <= sel_wdata;
        end
    end

    // Memory strobes in ISSUE, response in RESP, everything else held at 0.
    always_comb begin
        mem_data_i  = 1'b0;
        mem_data_o  = 1'b0;
        mem_width   = W_WORD;
        mem_signext = 1'b0;
        mem_addr    = 32'd0;
        mem_wdata   = 32'd0;
        rs_valid    = 2'b00;
        rs_err      = 1'b0;
        rs_rdata    = 32'd0;
        if (state == ST_ISSUE) begin
            mem_data_i  = we_q;
            mem_data_o  = ~we_q;
            mem_width   = (width_q == W_WORD_ALT) ? W_WORD : width_q;
            mem_signext = signext_q;
            mem_addr    = addr_q;
            mem_wdata   = wdata_q;
        end
        if (state == ST_RESP) begin
            rs_valid = owner_q ? 2'b10 : 2'b01;
            rs_err   = err_q;
            if (!we_q && !err_q) rs_rdata = mem_read;
        end
        dbg_state = state;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: table of single transactions plus hand-written
// sequences for contention, range/alignment errors and mid-flight reset.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int DB = 4096;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  rq_valid, rq_ready, rq_we, rq_signext, rq_width0, rq_width1;
    logic [31:0] rq_addr0, rq_addr1, rq_wdata0, rq_wdata1;
    logic [1:0]  rs_valid, mem_width;
    logic        rs_err, mem_data_i, mem_data_o, mem_signext;
    logic [31:0] rs_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_read = 32'd0;
    arb_state_t  dbg_state;

    dmem_arbiter #(.DMEM_BYTES(DB)) dut (
        .clk(clk), .rst_n(rst_n),
        .rq_valid(rq_valid), .rq_ready(rq_ready), .rq_we(rq_we), .rq_signext(rq_signext),
        .rq_width0(rq_width0), .rq_width1(rq_width1),
        .rq_addr0(rq_addr0), .rq_addr1(rq_addr1), .rq_wdata0(rq_wdata0), .rq_wdata1(rq_wdata1),
        .rs_valid(rs_valid), .rs_err(rs_err), .rs_rdata(rs_rdata),
        .mem_data_i(mem_data_i), .mem_data_o(mem_data_o), .mem_width(mem_width),
        .mem_signext(mem_signext), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset / counters ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;
    int strobes = 0;
    logic [31:0] last_addr;
    logic [1:0]  last_width;
    logic        last_we;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- memory model ----------------
    logic [7:0] mem [0:DB-1];

    function automatic logic [31:0] mem_load(input logic [31:0] a, input logic [1:0] w, input logic sx);
        int n;
        logic [31:0] v, idx;
        n = (w == 2'b01) ? 2 : (w == 2'b10) ? 1 : 4;
        v = 32'd0;
        for (int i = 0; i < n; i++) begin
            idx = a + 32'(i);
            v[8*i +: 8] = mem[idx % DB];
        end
        if (sx && n == 1) v = {{24{v[7]}}, v[7:0]};
        if (sx && n == 2) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    // Memory registers read data on the strobe edge.
    always @(posedge clk) begin
        if (mem_data_i) begin
            int n;
            logic [31:0] idx;
            n = (mem_width == 2'b01) ? 2 : (mem_width == 2'b10) ? 1 : 4;
            for (int i = 0; i < n; i++) begin
                idx = mem_addr + 32'(i);
                mem[idx % DB] = mem_wdata[8*i +: 8];
            end
        end
        if (mem_data_o) mem_read <= mem_load(mem_addr, mem_width, mem_signext);
    end

    // ---------------- scoreboard ----------------
    // Entry: {expected visible cycle[15:0], owner, err, rdata[31:0]}
    logic [49:0] exp_q[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (rs_valid != 2'b00) begin
                if (exp_q.size() == 0) begin
                    check("rs_unexpected", {62'd0, rs_valid}, 64'd0);
                end else begin
                    logic [49:0] e;
                    e = exp_q.pop_front();
                    check("rs_owner",   {62'd0, rs_valid}, e[33] ? 64'd2 : 64'd1);
                    check("rs_err",     {63'd0, rs_err},   {63'd0, e[32]});
                    check("rs_rdata",   {32'd0, rs_rdata}, {32'd0, e[31:0]});
                    check("rs_latency", 64'(cyc[15:0]),    64'(e[49:34]));
                end
            end else begin
                check("rs_err_idle", {63'd0, rs_err}, 64'd0);
            end
            if (mem_data_i || mem_data_o) begin
                strobes++;
                last_addr  = mem_addr;
                last_width = mem_width;
                last_we    = mem_data_i;
            end
        end
    end

    // ---------------- driver ----------------
    typedef struct {
        logic        req;
        logic        we;
        logic [1:0]  width;
        logic        sx;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    task automatic drive_fields(input vec_t v);
        rq_we[v.req]      = v.we;
        rq_signext[v.req] = v.sx;
        if (v.req) begin
            rq_width1 = v.width; rq_addr1 = v.addr; rq_wdata1 = v.wdata;
        end else begin
            rq_width0 = v.width; rq_addr0 = v.addr; rq_wdata0 = v.wdata;
        end
    endtask

    task automatic drain(input string name);
        for (int t = 0; t < 10 && exp_q.size() != 0; t++) @(posedge clk);
        @(negedge clk);
        check(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int  s0;
        bit  seen;
        logic [1:0] wexp;
        s0 = strobes;
        seen = 0;
        @(posedge clk); #1;
        drive_fields(v);
        rq_valid[v.req] = 1'b1;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (rq_ready[v.req]) begin
                seen = 1;
                check("ready_other", {63'd0, rq_ready[~v.req]}, 64'd0);
                exp_q.push_back({16'(cyc + (v.err ? 1 : 2)), v.req, v.err, v.rdata});
            end
        end
        if (!seen) begin
            check({name, "_ready_timeout"}, 64'd0, 64'd1);
            rq_valid = 2'b00;
            return;
        end
        @(posedge clk); #1;
        rq_valid[v.req] = 1'b0;
        drain({name, "_resp"});
        check({name, "_strobes"}, 64'(strobes - s0), v.err ? 64'd0 : 64'd1);
        if (!v.err) begin
            wexp = (v.width == 2'b11) ? 2'b00 : v.width;
            check({name, "_mem_addr"},  {32'd0, last_addr},  {32'd0, v.addr});
            check({name, "_mem_width"}, {62'd0, last_width}, {62'd0, wexp});
            check({name, "_mem_we"},    {63'd0, last_we},    {63'd0, v.we});
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ready"},  {62'd0, rq_ready}, 64'd0);
        check({name, "_rsv"},    {62'd0, rs_valid}, 64'd0);
        check({name, "_rserr"},  {63'd0, rs_err},   64'd0);
        check({name, "_rdata"},  {32'd0, rs_rdata}, 64'd0);
        check({name, "_strobe"}, {62'd0, mem_data_i, mem_data_o}, 64'd0);
        check({name, "_maddr"},  {32'd0, mem_addr}, 64'd0);
        check({name, "_state"},  {62'd0, dbg_state}, 64'(ST_IDLE));
    endtask

    // Hard stop so a stuck run still ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    vec_t vecs[15];

    initial begin
        logic        mis_err;
        int          grants;
        logic        exp_owner;
        bit          seen;
        vec_t        v;

        for (int i = 0; i < DB; i++) mem[i] = 8'h00;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        mis_err = 1'b1;
`else
        mis_err = 1'b0;
`endif
        //             req we   w      sx   addr           wdata          err      rdata
        vecs[0]  = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h10,        32'hDEADBEEF, 1'b0,   32'h0};
        vecs[1]  = '{1'b0, 1'b0, 2'b00, 1'b0, 32'h10,        32'h0,        1'b0,   32'hDEADBEEF};
        vecs[2]  = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h20,        32'h00000080, 1'b0,   32'h0};
        vecs[3]  = '{1'b0, 1'b0, 2'b10, 1'b1, 32'h20,        32'h0,        1'b0,   32'hFFFFFF80};
        vecs[4]  = '{1'b0, 1'b0, 2'b10, 1'b0, 32'h20,        32'h0,        1'b0,   32'h00000080};
        vecs[5]  = '{1'b1, 1'b1, 2'b01, 1'b0, 32'h30,        32'h1234ABCD, 1'b0,   32'h0};
        vecs[6]  = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h30,        32'h0,        1'b0,   32'hFFFFABCD};
        vecs[7]  = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h30,        32'h0,        1'b0,   32'h0000ABCD};
        vecs[8]  = '{1'b0, 1'b1, 2'b11, 1'b0, 32'h40,        32'hCAFEF00D, 1'b0,   32'h0};
        vecs[9]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h40,        32'h0,        1'b0,   32'hCAFEF00D};
        vecs[10] = '{1'b0, 1'b0, 2'b00, 1'b0, 32'(DB - 2),   32'h0,        1'b1,   32'h0};
        vecs[11] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'(DB - 1),   32'h0,        1'b0,   32'h0};
        vecs[12] = '{1'b0, 1'b0, 2'b01, 1'b0, 32'(DB - 1),   32'h0,        1'b1,   32'h0};
        vecs[13] = '{1'b0, 1'b0, 2'b01, 1'b0, 32'h21,        32'h0,        mis_err, 32'h0};
        vecs[14] = '{1'b1, 1'b1, 2'b00, 1'b0, 32'hFFFFFFFE,  32'h55AA55AA, 1'b1,   32'h0};

        // Reset with both requesters asking: nothing may be accepted.
        rst_n = 1'b0;
        rq_valid = 2'b11; rq_we = 2'b00; rq_signext = 2'b00;
        rq_width0 = 2'b00; rq_width1 = 2'b00;
        rq_addr0 = 32'h0; rq_addr1 = 32'h0; rq_wdata0 = 32'h0; rq_wdata1 = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rq_valid = 2'b00;
        @(posedge clk); #1 rst_n = 1'b1;

        for (int i = 0; i < 15; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Contention from reset: grants must alternate starting with requester 0.
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        v = '{1'b0, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0}; drive_fields(v);
        v = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0}; drive_fields(v);
        rq_valid = 2'b11;
        exp_owner = 1'b0;
        grants = 0;
        for (int t = 0; t < 40 && grants < 4; t++) begin
            @(negedge clk);
            if (rq_ready != 2'b00) begin
                check("alt_grant", {62'd0, rq_ready}, exp_owner ? 64'd2 : 64'd1);
                exp_q.push_back({16'(cyc + 2), exp_owner, 1'b0,
                                 exp_owner ? 32'hCAFEF00D : 32'hDEADBEEF});
                exp_owner = ~exp_owner;
                grants++;
            end
        end
        check("alt_grant_count", 64'(grants), 64'd4);
        @(posedge clk); #1 rq_valid = 2'b00;
        drain("alt_resp");

        // Reset while a load is in ISSUE: no response may follow.
        @(posedge clk); #1;
        v = '{1'b0, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0}; drive_fields(v);
        rq_valid = 2'b01;
        seen = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (rq_ready[0]) seen = 1;
        end
        check("rst_mid_accept", {63'd0, seen}, 64'd1);
        @(posedge clk); #1 rq_valid = 2'b00;
        check("rst_mid_in_issue", {62'd0, dbg_state}, 64'(ST_ISSUE));
        #1 rst_n = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            check_all_zero($sformatf("rst_mid%0d", t));
        end
        @(posedge clk); #1 rst_n = 1'b1;
        // Monitor flags any stray response here since the queue is empty.
        repeat (3) @(posedge clk);
        run_vec('{1'b0, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF}, "post_rst");

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
